// File: rtl/gtxe2_chnl_rx_oob.sv
// SATA out-of-band receive detector: classifies squelch bursts and gaps
// into COMINIT / COMWAKE sequences and pulses the matching detect output.
module gtxe2_chnl_rx_oob #(
  parameter int unsigned SATA_BURST_SEQ_LEN = 4,
  parameter int unsigned BURST_MIN          = 12,
  parameter int unsigned BURST_MAX          = 20,
  parameter int unsigned WAKE_GAP_MIN       = 12,
  parameter int unsigned WAKE_GAP_MAX       = 20,
  parameter int unsigned INIT_GAP_MIN       = 40,
  parameter int unsigned INIT_GAP_MAX       = 56
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_idle,
  output logic RXCOMINITDET,
  output logic RXCOMWAKEDET,
  output logic RXELECIDLE
);

  localparam int unsigned RUN_W = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_SAT  = '1;
  localparam logic [RUN_W-1:0] B_MIN    = RUN_W'(BURST_MIN);
  localparam logic [RUN_W-1:0] B_MAX    = RUN_W'(BURST_MAX);
  localparam logic [RUN_W-1:0] WG_MIN   = RUN_W'(WAKE_GAP_MIN);
  localparam logic [RUN_W-1:0] WG_MAX   = RUN_W'(WAKE_GAP_MAX);
  localparam logic [RUN_W-1:0] IG_MIN   = RUN_W'(INIT_GAP_MIN);
  localparam logic [RUN_W-1:0] IG_MAX   = RUN_W'(INIT_GAP_MAX);
  localparam logic [CNT_W-1:0] SEQ_LAST = CNT_W'(SATA_BURST_SEQ_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_WAIT_IDLE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_INIT,
    CLS_WAKE
  } cls_t;

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   bursts_cnt_q, bursts_cnt_d;
  cls_t               cls_q, cls_d;
  logic               init_det_d, wake_det_d;

  logic [RUN_W-1:0]   run_inc_c;
  logic               burst_ok_c;
  cls_t               gap_cls_c;

  // Saturating run increment and run-length classification
  always_comb begin
    run_inc_c  = (run_q == RUN_SAT) ? run_q : run_q + RUN_ONE;
    burst_ok_c = (run_q >= B_MIN) && (run_q <= B_MAX);
    gap_cls_c  = CLS_NONE;
    if ((run_q >= WG_MIN) && (run_q <= WG_MAX)) begin
      gap_cls_c = CLS_WAKE;
    end else if ((run_q >= IG_MIN) && (run_q <= IG_MAX)) begin
      gap_cls_c = CLS_INIT;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      run_q        <= '0;
      bursts_cnt_q <= '0;
      cls_q        <= CLS_NONE;
      RXCOMINITDET <= 1'b0;
      RXCOMWAKEDET <= 1'b0;
      RXELECIDLE   <= 1'b1;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      bursts_cnt_q <= bursts_cnt_d;
      cls_q        <= cls_d;
      RXCOMINITDET <= init_det_d;
      RXCOMWAKEDET <= wake_det_d;
      RXELECIDLE   <= rx_idle;
    end
  end

  // Next-state logic; every run restarts at 1 so sequences chain without dead cycles
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    bursts_cnt_d = bursts_cnt_q;
    cls_d        = cls_q;
    init_det_d   = 1'b0;
    wake_det_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_idle) begin
          state_d = ST_BURST;
          run_d   = RUN_ONE;
        end
      end

      ST_BURST: begin
        if (!rx_idle) begin
          if (run_q >= B_MAX) begin
            state_d      = ST_WAIT_IDLE;
            bursts_cnt_d = '0;
            cls_d        = CLS_NONE;
          end else begin
            run_d = run_inc_c;
          end
        end else if (burst_ok_c) begin
          if (bursts_cnt_q < SEQ_LAST) begin
            bursts_cnt_d = bursts_cnt_q + CNT_W'(1);
            state_d      = ST_GAP;
            run_d        = RUN_ONE;
          end else begin
            init_det_d   = (cls_q == CLS_INIT);
            wake_det_d   = (cls_q == CLS_WAKE);
            bursts_cnt_d = '0;
            cls_d        = CLS_NONE;
            state_d      = ST_IDLE;
          end
        end else begin
          bursts_cnt_d = '0;
          cls_d        = CLS_NONE;
          state_d      = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (rx_idle) begin
          if (run_q >= IG_MAX) begin
            bursts_cnt_d = '0;
            cls_d        = CLS_NONE;
            state_d      = ST_IDLE;
          end else begin
            run_d = run_inc_c;
          end
        end else begin
          state_d = ST_BURST;
          run_d   = RUN_ONE;
          // A bad or mismatched gap makes the current burst the first of a new sequence
          if ((gap_cls_c != CLS_NONE) && ((cls_q == CLS_NONE) || (cls_q == gap_cls_c))) begin
            cls_d = gap_cls_c;
          end else begin
            bursts_cnt_d = '0;
            cls_d        = CLS_NONE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_idle) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gtxe2_chnl_rx_oob.sv
// Scoreboard bench for gtxe2_chnl_rx_oob: burst/gap stimulus, a segment-level
// OOB model predicts detect pulses, a negedge monitor checks them.
module tb_gtxe2_chnl_rx_oob;

  localparam int SEQ_LEN  = 4;
  localparam int B_MIN    = 12;
  localparam int B_MAX    = 20;
  localparam int WG_MIN   = 12;
  localparam int WG_MAX   = 20;
  localparam int IG_MIN   = 40;
  localparam int IG_MAX   = 56;

  logic clk = 1'b0;
  logic reset_n;
  logic rx_idle;
  logic RXCOMINITDET, RXCOMWAKEDET, RXELECIDLE;

  gtxe2_chnl_rx_oob #(
    .SATA_BURST_SEQ_LEN(SEQ_LEN),
    .BURST_MIN(B_MIN), .BURST_MAX(B_MAX),
    .WAKE_GAP_MIN(WG_MIN), .WAKE_GAP_MAX(WG_MAX),
    .INIT_GAP_MIN(IG_MIN), .INIT_GAP_MAX(IG_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_idle(rx_idle),
    .RXCOMINITDET(RXCOMINITDET), .RXCOMWAKEDET(RXCOMWAKEDET),
    .RXELECIDLE(RXELECIDLE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_init;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Segment-level model: 0 none, 1 init, 2 wake
  int m_cnt = 0;
  int m_cls = 0;
  bit m_in_seq = 1'b0;
  int prev_gap = 0;

  function automatic int gap_type(int g);
    if (g >= WG_MIN && g <= WG_MAX) return 2;
    if (g >= IG_MIN && g <= IG_MAX) return 1;
    return 0;
  endfunction

  task automatic drive(bit v);
    @(posedge clk);
    #1;
    rx_idle = v;
  endtask

  // One burst of L active cycles followed by G idle cycles
  task automatic burst_gap(int L, int G);
    int t;
    int evt_cyc;
    if (m_in_seq) begin
      t = gap_type(prev_gap);
      if (t == 0 || (m_cls != 0 && m_cls != t)) begin
        m_cnt = 0;
        m_cls = 0;
      end else begin
        m_cls = t;
      end
    end else begin
      m_cnt = 0;
      m_cls = 0;
    end
    repeat (L) drive(1'b0);
    drive(1'b1);
    evt_cyc = cyc + 1;
    if (L < B_MIN || L > B_MAX) begin
      m_cnt = 0; m_cls = 0; m_in_seq = 1'b0;
    end else if (m_cnt + 1 < SEQ_LEN) begin
      m_cnt++;
      m_in_seq = 1'b1;
    end else begin
      if (m_cls != 0) exp_q.push_back('{evt_cyc, m_cls == 1});
      m_cnt = 0; m_cls = 0; m_in_seq = 1'b0;
    end
    repeat (G - 1) drive(1'b1);
    prev_gap = G;
  endtask

  task automatic apply_reset(int n);
    @(posedge clk);
    #1;
    rx_idle = 1'b1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (RXCOMINITDET !== 1'b0 || RXCOMWAKEDET !== 1'b0 || RXELECIDLE !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: init=%b wake=%b elecidle=%b, required 0 0 1",
               RXCOMINITDET, RXCOMWAKEDET, RXELECIDLE);
    end
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_cnt = 0; m_cls = 0; m_in_seq = 1'b0;
  endtask

  // Monitor: compare detect pulses against the scoreboard and RXELECIDLE against the line
  logic prev_idle = 1'b1;
  always @(negedge clk) begin
    if (!reset_n) begin
      vectors++;
      if (RXCOMINITDET !== 1'b0 || RXCOMWAKEDET !== 1'b0 || RXELECIDLE !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d: init=%b wake=%b elecidle=%b, required 0 0 1",
                 cyc, RXCOMINITDET, RXCOMWAKEDET, RXELECIDLE);
      end
    end else begin
      vectors++;
      if (RXELECIDLE !== prev_idle) begin
        miscompares++;
        $display("FAIL elecidle cyc=%0d: got %b, required %b", cyc, RXELECIDLE, prev_idle);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missed_pulse: detect output low at cyc %0d, required %s",
                 exp_q[0].cyc, exp_q[0].is_init ? "COMINIT" : "COMWAKE");
        void'(exp_q.pop_front());
      end
      if (RXCOMINITDET === 1'b1 || RXCOMWAKEDET === 1'b1) begin
        vectors++;
        if (RXCOMINITDET === 1'b1 && RXCOMWAKEDET === 1'b1) begin
          miscompares++;
          $display("FAIL both_pulses cyc=%0d: init=1 wake=1, required at most one", cyc);
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          if (RXCOMINITDET !== exp_q[0].is_init) begin
            miscompares++;
            $display("FAIL pulse_type cyc=%0d: init=%b wake=%b, required init=%b",
                     cyc, RXCOMINITDET, RXCOMWAKEDET, exp_q[0].is_init);
          end
          void'(exp_q.pop_front());
        end else begin
          miscompares++;
          $display("FAIL unexpected_pulse cyc=%0d: init=%b wake=%b, required none",
                   cyc, RXCOMINITDET, RXCOMWAKEDET);
        end
      end
    end
    prev_idle <= rx_idle;
  end

  int gsel[6] = '{11, 21, 30, 39, 57, 60};

  initial begin
    int L, G, nb;
    bit wake_mode;
    reset_n = 1'b0;
    rx_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) drive(1'b1);

    // COMINIT and COMWAKE
    repeat (4) burst_gap(16, 48);
    repeat (4) burst_gap(16, 16);
    // Mismatched gap restarts the sequence at burst 3
    burst_gap(16, 48); burst_gap(16, 16); burst_gap(16, 48);
    burst_gap(16, 48); burst_gap(16, 48); burst_gap(16, 48);
    // Over-long burst ignored, then a legal COMINIT
    burst_gap(30, 48);
    repeat (4) burst_gap(16, 48);
    // Bad gaps inside a sequence
    burst_gap(16, 48); burst_gap(16, 30); burst_gap(16, 48); burst_gap(16, 60);
    burst_gap(16, 16); burst_gap(16, 16); burst_gap(16, 60); burst_gap(16, 16);
    // Boundary lengths
    repeat (4) burst_gap(12, 12);
    repeat (4) burst_gap(20, 20);
    repeat (4) burst_gap(12, 40);
    repeat (4) burst_gap(20, 56);
    burst_gap(16, 16); burst_gap(11, 16); burst_gap(16, 16); burst_gap(21, 16);
    burst_gap(16, 11); burst_gap(16, 21); burst_gap(16, 39); burst_gap(16, 57);
    repeat (4) burst_gap(16, 16);
    // Reset after partial COMWAKE progress
    burst_gap(16, 16); burst_gap(16, 10);
    apply_reset(3);
    repeat (3) drive(1'b1);
    repeat (2) burst_gap(16, 16);
    repeat (4) burst_gap(16, 16);

    // Randomized sequences, mostly legal with occasional out-of-range lengths
    for (int s = 0; s < 70; s++) begin
      wake_mode = 1'($urandom_range(0, 1));
      nb = $urandom_range(3, 6);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 9) == 0) L = $urandom_range(8, 24);
        else L = $urandom_range(B_MIN, B_MAX);
        if ($urandom_range(0, 9) == 0) G = gsel[$urandom_range(0, 5)];
        else if (wake_mode) G = $urandom_range(WG_MIN, WG_MAX);
        else G = $urandom_range(IG_MIN, IG_MAX);
        burst_gap(L, G);
      end
      if ($urandom_range(0, 19) == 0) begin
        apply_reset($urandom_range(1, 4));
        drive(1'b1);
      end
    end

    repeat (20) drive(1'b1);
    while (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse_end: detect output low at cyc %0d, required %s",
               exp_q[0].cyc, exp_q[0].is_init ? "COMINIT" : "COMWAKE");
      void'(exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_rx_oob.md
GTXE2_CHNL_RX_OOB -- requirements
Module: gtxe2_chnl_rx_oob

Interface
REQ-001 Parameter SATA_BURST_SEQ_LEN, default 4, is the number of valid bursts that make one OOB signal; legal range is 2..15.
REQ-002 Parameters BURST_MIN and BURST_MAX, defaults 12 and 20, give the inclusive legal burst length in clk cycles.
REQ-003 Parameters WAKE_GAP_MIN and WAKE_GAP_MAX, defaults 12 and 20, give the inclusive COMWAKE gap length in clk cycles.
REQ-004 Parameters INIT_GAP_MIN and INIT_GAP_MAX, defaults 40 and 56, give the inclusive COMINIT gap length in clk cycles; all length parameters are at most 254.
REQ-005 clk  in  1  receive user clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 rx_idle  in  1  squelch output; 1 means the line is quiet this cycle, 0 means burst activity.
REQ-008 RXCOMINITDET  out  1  one-cycle pulse when a COMINIT sequence is recognised.
REQ-009 RXCOMWAKEDET  out  1  one-cycle pulse when a COMWAKE sequence is recognised.
REQ-010 RXELECIDLE  out  1  rx_idle delayed by one clk cycle through a register.

Function
REQ-011 The FSM has four states: IDLE, BURST, GAP and WAIT_IDLE.
REQ-012 An 8-bit run counter holds the length of the current burst or gap, counting the first cycle as 1; it saturates at 255.
REQ-013 A 4-bit bursts_cnt counts valid bursts; a 2-bit class register holds NONE, INIT or WAKE.
REQ-014 IDLE: when rx_idle=0, go to BURST with run=1.
REQ-015 BURST, rx_idle=0: run increments; if run would exceed BURST_MAX, go to WAIT_IDLE and clear bursts_cnt and class.
REQ-016 BURST, rx_idle=1, run inside [BURST_MIN, BURST_MAX], and bursts_cnt+1 < SATA_BURST_SEQ_LEN: bursts_cnt increments, go to GAP with run=1.
REQ-017 BURST, rx_idle=1, run inside [BURST_MIN, BURST_MAX], and bursts_cnt+1 = SATA_BURST_SEQ_LEN: pulse the detect output for the current class, clear bursts_cnt and class, go to IDLE.
REQ-018 BURST, rx_idle=1, run < BURST_MIN: clear bursts_cnt and class, go to IDLE, no detect pulse.
REQ-019 GAP, rx_idle=1: run increments; if run would exceed INIT_GAP_MAX, clear bursts_cnt and class and go to IDLE.
REQ-020 GAP, rx_idle=0: classify the gap as WAKE (inside the wake range), INIT (inside the init range) or invalid.
REQ-021 If class=NONE and the gap is valid, class takes the gap type; if class is set and the gap type matches, class is kept. In both cases go to BURST with run=1.
REQ-022 Gap invalid or type mismatch: clear bursts_cnt, set class to NONE, go to BURST with run=1, so the current burst becomes burst 1 of a new sequence.
REQ-023 WAIT_IDLE: stay until rx_idle=1, then go to IDLE.
REQ-024 Detect outputs are registered and high for exactly one cycle, starting the cycle after the clk edge that sampled the first rx_idle=1 following burst N.
REQ-025 RXCOMINITDET and RXCOMWAKEDET are never high in the same cycle.
REQ-026 A detect pulse needs exactly SATA_BURST_SEQ_LEN bursts; a trailing gap after the last burst is not required.
REQ-027 Because every run starts at 1, back-to-back sequences are detected with no dead cycles.

Reset
REQ-028 reset_n=0 immediately forces state to IDLE, run=0, bursts_cnt=0, class=NONE, RXCOMINITDET=0, RXCOMWAKEDET=0 and RXELECIDLE=1.
REQ-029 After reset_n rises, a full sequence is needed; partial progress made before the reset is never credited.

Verification
REQ-030 4 bursts of 16 cycles with 48-cycle gaps -> RXCOMINITDET high for 1 cycle, one cycle after the 4th burst ends; RXCOMWAKEDET stays 0.
REQ-031 4 bursts of 16 cycles with 16-cycle gaps -> a single RXCOMWAKEDET pulse; RXCOMINITDET stays 0.
REQ-032 Bursts of 16 cycles with gaps 48, 16, 48, 48, 48 -> no pulse through burst 5; RXCOMINITDET pulses after burst 6 (restart at burst 3).
REQ-033 One 30-cycle burst, then 4 legal COMINIT bursts -> the long burst is ignored via WAIT_IDLE, and one RXCOMINITDET pulse follows the 4th legal burst.
REQ-034 A 30-cycle gap or a 60-cycle gap inside a sequence -> no pulse; a 60-cycle gap returns the FSM to IDLE at cycle 57.
REQ-035 reset_n low for 3 cycles after 2 valid COMWAKE bursts -> outputs reset per REQ-028; a pulse occurs only after 4 further valid bursts.
